neuron_accumulator: RTL and testbench
=====================================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 4, giving the number of 16-bit operands summed per neuron evaluation (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, which begins an evaluation when sampled high in IDLE.
REQ-005 The block SHALL have port bias, input, 16 bits, a two's-complement initial accumulator value sampled with start.
REQ-006 The block SHALL have ports in_valid (input, 1), in_data (input, 16, two's-complement weighted product) and in_ready (output, 1), forming the operand handshake.
REQ-007 The block SHALL have ports out_valid (output, 1), out_data (output, 16, neuron result) and out_ready (input, 1), forming the result handshake.
REQ-008 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-009 The block SHALL implement states IDLE, ACC and OUT.
REQ-010 In IDLE with start=1, the block SHALL load acc<=bias, count<=0 and enter ACC on the next edge.
REQ-011 In ACC, in_ready SHALL be 1; in_ready SHALL be 0 in IDLE and OUT.
REQ-012 A beat SHALL be accepted only on an edge where in_valid=1 and in_ready=1; it SHALL update acc<=acc+in_data and count<=count+1.
REQ-013 Stalls (in_valid=0 in ACC) SHALL hold acc and count unchanged for any number of cycles.
REQ-014 When the beat with count==N_INPUTS-1 is accepted, the block SHALL enter OUT on that edge; out_valid SHALL be high in the following cycle (1-cycle latency from last beat).
REQ-015 In OUT, out_valid SHALL be 1 and out_data SHALL equal acc, held stable until out_valid&&out_ready.
REQ-016 On out_valid&&out_ready the block SHALL return to IDLE; out_valid SHALL be 0 the next cycle.
REQ-017 start SHALL be ignored in ACC and OUT; a start asserted in the same cycle as the OUT handshake SHALL be ignored (evaluation begins only from IDLE).
REQ-018 Default addition SHALL be 16-bit modular: carry-out discarded, result wraps (0x7FFF+0x0001=0x8000).
REQ-019 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously force state=IDLE, acc=0, count=0, out_valid=0, out_data=0, in_ready=0, busy=0.
REQ-021 A reset asserted mid-evaluation SHALL discard the partial sum; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-022 With macro NEURON_ACC_SATURATE_EN defined, each accumulation SHALL saturate to signed 16-bit: positive overflow yields 0x7FFF, negative overflow yields 0x8000.
REQ-023 Without NEURON_ACC_SATURATE_EN, accumulation SHALL wrap per REQ-018; all other behaviour SHALL be identical.

Verification
REQ-024 N_INPUTS=4, bias=0x0010, beats 0x0001,0x0002,0x0003,0x0004 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=0x001A, then IDLE.
REQ-025 Same operands with in_valid deasserted 3 cycles between beats and out_ready held 0 for 5 cycles -> out_data=0x001A stable throughout, in_ready=0 in OUT, single result handshake.
REQ-026 bias=0x7FFF, beats 0x0001,0,0,0 -> out_data=0x8000 without macro; 0x7FFF with NEURON_ACC_SATURATE_EN.
REQ-027 bias=0x8000, beats 0xFFFF,0,0,0 -> out_data=0x7FFF without macro; 0x8000 with NEURON_ACC_SATURATE_EN.
REQ-028 rst_n pulsed low after 2 accepted beats -> outputs zero immediately (asynchronously); a new start with bias=0, beats 1,1,1,1 yields out_data=0x0004.
REQ-029 start pulsed during ACC and during the OUT handshake cycle -> no reload of acc, result unchanged, block idles after handshake.

Source files
------------

// File: rtl/neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : neuron_accumulator
// Description : Sums N_INPUTS signed 16-bit operands onto a signed 16-bit bias
//               and presents the result through a valid/ready handshake.
//               Three-state control: IDLE -> ACC -> OUT -> IDLE.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : N_INPUTS   operands summed per evaluation (1..255)
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               start      begin an evaluation (honoured only in IDLE)
//               bias       initial accumulator value, sampled with start
//               in_valid   operand valid
//               in_data    signed operand
//               in_ready   operand accepted this cycle when also in_valid
//               out_valid  result valid
//               out_data   result (0 whenever out_valid is low)
//               out_ready  result consumer ready
//               busy       evaluation in progress (state != IDLE)
// Build macro : NEURON_ACC_SATURATE_EN - saturate each accumulation to the
//               signed 16-bit range instead of wrapping.
// ============================================================================
module neuron_accumulator #(
  parameter int N_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Index of the final operand of an evaluation.
  localparam logic [7:0] c_last_idx = 8'(N_INPUTS - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_acc;
  logic [7:0]  r_count;
  logic [15:0] w_sum;
  logic        w_beat;
  logic        w_load;

  // Outputs decode purely from state so that the asynchronous reset clears
  // them immediately.
  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = out_valid ? r_acc : 16'h0000;

  assign w_beat = in_valid && (r_state == S_ACC);
  assign w_load = start && (r_state == S_IDLE);

`ifdef NEURON_ACC_SATURATE_EN
  // Sign-extended sum; bits 16 and 15 disagree exactly on signed overflow,
  // and bit 16 then carries the true sign of the result.
  logic [16:0] w_sum_ext;
  assign w_sum_ext = {r_acc[15], r_acc} + {in_data[15], in_data};
  always_comb begin
    w_sum = w_sum_ext[15:0];
    if (w_sum_ext[16] != w_sum_ext[15]) begin
      w_sum = w_sum_ext[16] ? 16'h8000 : 16'h7FFF;
    end
  end
`else
  // Modular addition: carry-out is simply dropped.
  assign w_sum = r_acc + in_data;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid && (r_count == c_last_idx)) begin
          w_next_state = S_OUT;
        end
      end
      S_OUT: begin
        // A start in this cycle is deliberately not looked at; a new
        // evaluation can only begin once IDLE has been reached.
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Accumulator datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= 16'h0000;
      r_count <= 8'h00;
    end else if (w_load) begin
      r_acc   <= bias;
      r_count <= 8'h00;
    end else if (w_beat) begin
      r_acc   <= w_sum;
      r_count <= r_count + 8'h01;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_accumulator
// Description : Directed self-checking bench for neuron_accumulator
//               (N_INPUTS = 4). Inputs change on the falling edge and
//               outputs are compared on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_accumulator;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  neuron_accumulator #(
    .N_INPUTS(4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bias     (bias),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid beat, then 'gap' idle cycles with in_valid low.
  task automatic beat(input logic [15:0] d, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h0000;
    for (int g = 0; g < gap; g++) @(negedge clk);
  endtask

  // Pulse start for one cycle with the given bias; ends one cycle later.
  task automatic kick(input logic [15:0] b);
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    bias  = 16'h0000;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    bias      = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_out_valid", {15'h0, out_valid}, 16'h0000);
    check("rst_out_data",  out_data,           16'h0000);
    check("rst_in_ready",  {15'h0, in_ready},  16'h0000);
    check("rst_busy",      {15'h0, busy},      16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {15'h0, busy}, 16'h0000);

    // ---------------- back-to-back: 0x10+1+2+3+4 = 0x1A ----------------
    kick(16'h0010);
    check("acc_in_ready", {15'h0, in_ready}, 16'h0001);
    check("acc_busy",     {15'h0, busy},     16'h0001);
    beat(16'h0001, 0);
    beat(16'h0002, 0);
    beat(16'h0003, 0);
    check("b2b_no_early_valid", {15'h0, out_valid}, 16'h0000);
    check("b2b_data_zero",      out_data,           16'h0000);
    beat(16'h0004, 0);
    check("b2b_out_valid", {15'h0, out_valid}, 16'h0001);
    check("b2b_out_data",  out_data,           16'h001A);
    check("b2b_in_ready",  {15'h0, in_ready},  16'h0000);
    @(negedge clk);
    check("b2b_done_valid", {15'h0, out_valid}, 16'h0000);
    check("b2b_done_busy",  {15'h0, busy},      16'h0000);

    // ---------------- stalls + backpressure ----------------
    out_ready = 1'b0;
    kick(16'h0010);
    beat(16'h0001, 3);
    check("stall_in_ready", {15'h0, in_ready},  16'h0001);
    check("stall_no_valid", {15'h0, out_valid}, 16'h0000);
    beat(16'h0002, 3);
    beat(16'h0003, 3);
    beat(16'h0004, 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {15'h0, out_valid}, 16'h0001);
      check("bp_out_data",  out_data,           16'h001A);
      check("bp_in_ready",  {15'h0, in_ready},  16'h0000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", {15'h0, out_valid}, 16'h0000);
    repeat (2) @(negedge clk);
    check("bp_single_hs", {15'h0, out_valid}, 16'h0000);

    // ---------------- positive overflow ----------------
    kick(16'h7FFF);
    beat(16'h0001, 0);
    beat(16'h0000, 0);
    beat(16'h0000, 0);
    beat(16'h0000, 0);
`ifdef NEURON_ACC_SATURATE_EN
    check("pos_ovf", out_data, 16'h7FFF);
`else
    check("pos_ovf", out_data, 16'h8000);
`endif
    @(negedge clk);

    // ---------------- negative overflow ----------------
    kick(16'h8000);
    beat(16'hFFFF, 0);
    beat(16'h0000, 0);
    beat(16'h0000, 0);
    beat(16'h0000, 0);
`ifdef NEURON_ACC_SATURATE_EN
    check("neg_ovf", out_data, 16'h8000);
`else
    check("neg_ovf", out_data, 16'h7FFF);
`endif
    @(negedge clk);

    // ---------------- reset mid-evaluation ----------------
    kick(16'h1234);
    beat(16'h0011, 0);
    beat(16'h0022, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", {15'h0, in_ready},  16'h0000);
    check("async_rst_busy",     {15'h0, busy},      16'h0000);
    check("async_rst_out_data", out_data,           16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0005;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_idle", {15'h0, busy}, 16'h0000);
    kick(16'h0000);
    beat(16'h0001, 0);
    beat(16'h0001, 0);
    beat(16'h0001, 0);
    beat(16'h0001, 0);
    check("post_rst_sum", out_data, 16'h0004);
    @(negedge clk);

    // ---------------- start ignored in ACC and OUT ----------------
    out_ready = 1'b0;
    kick(16'h0100);
    start = 1'b1;
    bias  = 16'h7000;
    beat(16'h0001, 0);
    beat(16'h0002, 0);
    beat(16'h0003, 0);
    beat(16'h0004, 0);
    check("start_acc_ignored", out_data, 16'h010A);
    @(negedge clk);
    check("start_out_ignored", out_data, 16'h010A);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bias  = 16'h0000;
    check("start_hs_idle_busy",  {15'h0, busy},      16'h0000);
    check("start_hs_idle_valid", {15'h0, out_valid}, 16'h0000);
    @(negedge clk);
    check("start_hs_stays_idle", {15'h0, busy}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
